evr_multi_pulse_gen: RTL
========================

Name: evr_multi_pulse_gen

Overview:
- NUM_CH-channel event-triggered pulse generator for the EVR receive path; runs in the recovered receive clock domain.
- Each channel matches the decoded 8-bit event stream against its own event code, waits a programmable delay, emits a programmable-width pulse of selectable polarity, latches the 64-bit timestamp at the trigger, and counts matches.
- Generalises the single fixed-code delay/width gates (DMA trigger, time sync) into one configurable block with retrigger mode and per-channel diagnostics.

Parameters:
- NUM_CH, 4, number of independent trigger channels (1..16)
- DLY_W, 32, width of per-channel delay field, in clock cycles
- WID_W, 32, width of per-channel pulse-width field, in clock cycles
- CNT_W, 32, width of per-channel event counter
- RETRIG, 0, 0 = ignore matches while busy; 1 = a match while busy restarts the sequence

Ports:
- Clk  in  1  receive user clock (EVR recovered clock)
- reset_n  in  1  asynchronous, active-low reset
- EventStream  in  8  decoded event code per cycle; 0x00 = no event
- TimeStamp  in  64  current time-of-day, synchronous to Clk
- ch_enable  in  NUM_CH  per-channel enable
- ch_code  in  NUM_CH*8  per-channel event code; channel i uses bits [8i+7:8i]
- ch_delay  in  NUM_CH*DLY_W  per-channel delay
- ch_width  in  NUM_CH*WID_W  per-channel pulse width
- ch_pol  in  NUM_CH  output polarity: 0 = active-high, 1 = active-low
- cnt_clear  in  NUM_CH  synchronous clear of event counter
- pulse_out  out  NUM_CH  channel pulses
- busy  out  NUM_CH  channel in DELAY or PULSE
- ts_valid  out  NUM_CH  1-cycle strobe when ts_latched updates
- ts_latched  out  NUM_CH*64  TimeStamp captured at the accepted match
- evt_count  out  NUM_CH*CNT_W  matches seen

Behaviour:
- Reset (reset_n low, asynchronous):
  - every channel goes to IDLE
  - busy, ts_valid, ts_latched and evt_count clear to 0
  - pulse_out = ch_pol (inactive level)
- Match, channel i, cycle T: ch_enable[i]=1 AND EventStream==code_i AND code_i!=0x00. Code 0x00 never matches.
- Per-channel FSM states: IDLE, DELAY, PULSE.
- Accepted match: a match in IDLE, or any match when RETRIG=1.
  - latch D=delay_i and W=width_i; later config changes do not affect the running sequence
  - ts_latched_i <= TimeStamp at cycle T; ts_valid_i is high for cycle T+1 only
- Transitions after an accepted match at T:
  - D>0: DELAY during T+1..T+D, then PULSE during T+D+1..T+D+W, then IDLE.
  - D=0: PULSE starts at T+1.
  - W=0: no pulse; return to IDLE after any delay. Timestamp and count still update.
- pulse_out_i = (state==PULSE) XOR ch_pol_i. It is decoded from registered state only, so it is glitch-free.
- busy_i = (state != IDLE).
- RETRIG=0:
  - matches during DELAY or PULSE are counted only.
  - no restart, no timestamp latch, no ts_valid.
- RETRIG=1:
  - a match during DELAY or PULSE reloads D/W and restarts the sequence from cycle T as above.
  - if the new D>0, a running pulse deasserts at T+1.
  - if the new D=0, the pulse stays asserted and the new W counts from T+1.
- Disable: ch_enable_i deasserted in any state forces IDLE at the next edge. pulse_out returns to the inactive level, with no truncation glitch. A match on the same cycle is not accepted.
- Counter:
  - evt_count_i increments on every match, accepted or not.
  - it wraps from all-ones to 0.
  - cnt_clear_i alone gives 0 at the next edge.
  - cnt_clear_i together with a match gives 1.
- Channels are fully independent. One event code may match several channels in the same cycle, and each channel acts on it.
- Counters: delay and width down-counters are DLY_W and WID_W bits. Maximum delay is 2^DLY_W-1 with no overflow.

Test Plan:
- Ch0 code 0x30, D=5, W=3, pol=0; EventStream=0x30 at T -> busy T+1..T+8; pulse_out[0] high T+6..T+8; ts_valid T+1 with ts_latched = TimeStamp(T); evt_count=1.
- Ch1 D=0, W=1, pol=1; match at T -> pulse_out[1] low exactly at T+1, high otherwise; W=0 variant -> no pulse, evt_count still increments.
- RETRIG=0, D=2, W=10; second match at T+5 -> pulse unchanged (T+3..T+12); evt_count=2; only one ts_valid. RETRIG=1 same stimulus -> pulse deasserts T+6, reasserts T+8..T+17; two ts_valid strobes.
- Code 0x7D on ch0 and ch2 simultaneously, different delays -> both fire independently; code 0x00 configured -> EventStream 0x00 never counts.
- Disable ch0 mid-PULSE -> pulse_out inactive next cycle, busy 0. Assert reset_n low mid-DELAY -> all outputs at reset values immediately, with no pulse after release.
- CNT_W=4: 15 matches then 1 more -> evt_count 15 then 0. cnt_clear together with a match -> 1.

Source files
------------

// File: rtl/evr_multi_pulse_gen.sv
// Purpose : NUM_CH independent event-triggered delay/width pulse generators for the EVR receive path.
// Latency : match at cycle T -> ts_valid at T+1; pulse starts at T+D+1 (T+1 when D=0) and lasts W cycles.
// Backpres: none. Every cycle's event code is consumed. Matches while busy are counted, or restart the channel when RETRIG=1.
//
// Ports:
//   Clk, reset_n      recovered receive clock, asynchronous active-low reset
//   EventStream       decoded event code per cycle (0x00 = no event)
//   TimeStamp         64-bit time-of-day, synchronous to Clk
//   ch_enable         per-channel enable; deasserting it forces the channel idle at the next edge
//   ch_code           per-channel event code, channel i in bits [8i+7:8i]; code 0x00 never matches
//   ch_delay          per-channel delay in cycles (DLY_W bits each)
//   ch_width          per-channel pulse width in cycles (WID_W bits each); 0 = no pulse
//   ch_pol            per-channel polarity (0 = active-high, 1 = active-low)
//   cnt_clear         per-channel synchronous clear of the event counter
//   pulse_out         channel pulses, decoded from registered state
//   busy              channel is in DELAY or PULSE
//   ts_valid          1-cycle strobe when ts_latched updates
//   ts_latched        TimeStamp captured at the accepted match (64 bits each)
//   evt_count         number of matches seen (CNT_W bits each, wraps)
module evr_multi_pulse_gen #(
   parameter int NUM_CH = 4,
   parameter int DLY_W  = 32,
   parameter int WID_W  = 32,
   parameter int CNT_W  = 32,
   parameter int RETRIG = 0
) (
   input  logic                      Clk,
   input  logic                      reset_n,
   input  logic [7:0]                EventStream,
   input  logic [63:0]               TimeStamp,
   input  logic [NUM_CH-1:0]         ch_enable,
   input  logic [NUM_CH*8-1:0]       ch_code,
   input  logic [NUM_CH*DLY_W-1:0]   ch_delay,
   input  logic [NUM_CH*WID_W-1:0]   ch_width,
   input  logic [NUM_CH-1:0]         ch_pol,
   input  logic [NUM_CH-1:0]         cnt_clear,
   output logic [NUM_CH-1:0]         pulse_out,
   output logic [NUM_CH-1:0]         busy,
   output logic [NUM_CH-1:0]         ts_valid,
   output logic [NUM_CH*64-1:0]      ts_latched,
   output logic [NUM_CH*CNT_W-1:0]   evt_count
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DELAY = 2'd1,
      ST_PULSE = 2'd2
   } state_t;

   localparam logic RETRIG_EN = (RETRIG != 0);

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch

      // Per-channel configuration slices
      logic [7:0]       w_code;
      logic [DLY_W-1:0] w_dly;
      logic [WID_W-1:0] w_wid;
      logic             w_match;
      logic             w_accept;

      // Channel state
      state_t           r_state;
      logic [DLY_W-1:0] r_dly_cnt;
      logic [WID_W-1:0] r_wid_cnt;
      logic             r_pulse;
      logic             r_busy;
      logic             r_ts_vld;
      logic [63:0]      r_ts;
      logic [CNT_W-1:0] r_cnt;

      assign w_code = ch_code[g*8 +: 8];
      assign w_dly  = ch_delay[g*DLY_W +: DLY_W];
      assign w_wid  = ch_width[g*WID_W +: WID_W];

      // A disabled channel never matches, so it neither counts nor restarts.
      assign w_match  = ch_enable[g] && (w_code != 8'h00) && (EventStream == w_code);
      assign w_accept = w_match && (RETRIG_EN || (r_state == ST_IDLE));

      // Sequencer. D and W are captured on acceptance: the delay counter runs
      // down from D, and the width counter holds W through the delay phase
      // before running down from W during the pulse.
      always_ff @(posedge Clk or negedge reset_n) begin
         if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_dly_cnt <= '0;
            r_wid_cnt <= '0;
            r_pulse   <= 1'b0;
            r_busy    <= 1'b0;
            r_ts_vld  <= 1'b0;
            r_ts      <= '0;
         end else begin
            r_ts_vld <= 1'b0;
            if (!ch_enable[g]) begin
               r_state <= ST_IDLE;
               r_pulse <= 1'b0;
               r_busy  <= 1'b0;
            end else if (w_accept) begin
               r_ts      <= TimeStamp;
               r_ts_vld  <= 1'b1;
               r_dly_cnt <= w_dly;
               r_wid_cnt <= w_wid;
               if (w_dly != '0) begin
                  r_state <= ST_DELAY;
                  r_pulse <= 1'b0;
                  r_busy  <= 1'b1;
               end else if (w_wid != '0) begin
                  // A zero-delay retrigger during PULSE keeps the pulse high
                  r_state <= ST_PULSE;
                  r_pulse <= 1'b1;
                  r_busy  <= 1'b1;
               end else begin
                  r_state <= ST_IDLE;
                  r_pulse <= 1'b0;
                  r_busy  <= 1'b0;
               end
            end else begin
               case (r_state)
                  ST_DELAY: begin
                     if (r_dly_cnt == DLY_W'(1)) begin
                        if (r_wid_cnt != '0) begin
                           r_state <= ST_PULSE;
                           r_pulse <= 1'b1;
                           r_busy  <= 1'b1;
                        end else begin
                           r_state <= ST_IDLE;
                           r_pulse <= 1'b0;
                           r_busy  <= 1'b0;
                        end
                     end else begin
                        r_dly_cnt <= r_dly_cnt - DLY_W'(1);
                     end
                  end
                  ST_PULSE: begin
                     if (r_wid_cnt == WID_W'(1)) begin
                        r_state <= ST_IDLE;
                        r_pulse <= 1'b0;
                        r_busy  <= 1'b0;
                     end else begin
                        r_wid_cnt <= r_wid_cnt - WID_W'(1);
                     end
                  end
                  default: begin
                     r_state <= ST_IDLE;
                     r_pulse <= 1'b0;
                     r_busy  <= 1'b0;
                  end
               endcase
            end
         end
      end

      // Event counter. A clear that coincides with a match yields 1, so that
      // match is not lost.
      always_ff @(posedge Clk or negedge reset_n) begin
         if (!reset_n) begin
            r_cnt <= '0;
         end else if (cnt_clear[g]) begin
            r_cnt <= w_match ? CNT_W'(1) : '0;
         end else if (w_match) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end

      // Polarity is static configuration, so it is XORed with the registered
      // pulse flag. This keeps the output glitch-free and makes reset show
      // the inactive level immediately.
      assign pulse_out[g]                 = r_pulse ^ ch_pol[g];
      assign busy[g]                      = r_busy;
      assign ts_valid[g]                  = r_ts_vld;
      assign ts_latched[g*64 +: 64]       = r_ts;
      assign evt_count[g*CNT_W +: CNT_W]  = r_cnt;
   end

endmodule
